// File: rtl/sysbus_pkg.sv
// ============================================================================
// Module   : sysbus_pkg
// Purpose  : Shared tag layout, tag constants and responder FSM states.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sysbus_pkg;

  localparam int TAG_RW       = 12;
  localparam int TAG_TYPE_MSB = 11;
  localparam int TAG_TYPE_LSB = 8;
  localparam int TAG_ID_MSB   = 7;
  localparam int TAG_ID_LSB   = 0;

  localparam logic       READ   = 1'b1;
  localparam logic       WRITE  = 1'b0;
  localparam logic [3:0] MEMORY = 4'b0001;
  localparam logic [3:0] MMIO   = 4'b0011;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DATA = 2'd1,
    RD_WAIT = 2'd2,
    RD_RESP = 2'd3
  } resp_state_t;

endpackage

`default_nettype wire

// File: rtl/sysbus_mem_array.sv
// ============================================================================
// Module   : sysbus_mem_array
// Purpose  : Single-port word store, synchronous write, combinational read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sysbus_mem_array #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 1024,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  // Contents deliberately survive reset.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

`default_nettype wire

// File: rtl/sysbus_mem_responder.sv
// ============================================================================
// Module   : sysbus_mem_responder
// Purpose  : System-bus memory target: burst writes, latency-delayed burst reads.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sysbus_mem_responder
  import sysbus_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int BEATS          = 8,
  parameter int DEPTH          = 1024,
  parameter int LATENCY        = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      bus_respack
);

  localparam int ADDR_W     = $clog2(DEPTH);
  localparam int BEAT_W     = $clog2(BEATS);
  localparam int LAT_W      = $clog2(LATENCY + 1);
  localparam int BYTE_SHIFT = $clog2(BUS_DATA_WIDTH / 8);

  localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'(BEATS - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD   = LAT_W'(LATENCY);

  resp_state_t              state_q, state_d;
  logic [ADDR_W-1:0]        base_q, base_d;
  logic [BEAT_W-1:0]        beat_q, beat_d;
  logic [LAT_W-1:0]         lat_q, lat_d;
  logic [BUS_TAG_WIDTH-1:0] tag_q, tag_d;

  logic                      req_xfer;
  logic                      resp_xfer;
  logic                      last_beat;
  logic                      req_is_read;
  logic [ADDR_W-1:0]         req_base;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [BUS_DATA_WIDTH-1:0] mem_rdata;

  assign req_xfer    = bus_reqcyc & bus_reqack;
  assign resp_xfer   = bus_respcyc & bus_respack;
  assign last_beat   = (beat_q == LAST_BEAT);
  assign req_is_read = (bus_reqtag[TAG_RW] == READ);
  // Byte address -> word index, aligned down to the start of its burst block.
  assign req_base    = bus_req[BYTE_SHIFT +: ADDR_W] & BLOCK_MASK;

  // Base is block-aligned, so base + beat stays inside one block.
  assign mem_addr    = base_q + ADDR_W'(beat_q);
  assign mem_we      = reset_n && (state_q == WR_DATA) && bus_reqcyc;

  sysbus_mem_array #(
    .DATA_WIDTH (BUS_DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (bus_req),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_xfer) state_d = req_is_read ? RD_WAIT : WR_DATA;
      WR_DATA: if (req_xfer && last_beat) state_d = IDLE;
      RD_WAIT: if (lat_q <= LAT_W'(1)) state_d = RD_RESP;
      RD_RESP: if (resp_xfer && last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus_reqack  = (state_q == IDLE) || (state_q == WR_DATA);
    bus_respcyc = 1'b0;
    bus_resp    = '0;
    bus_resptag = '0;
    if (state_q == RD_RESP) begin
      bus_respcyc = 1'b1;
      bus_resp    = mem_rdata;
      bus_resptag = tag_q;
    end
  end

  always_comb begin
    base_d = base_q;
    beat_d = beat_q;
    lat_d  = lat_q;
    tag_d  = tag_q;
    case (state_q)
      IDLE: begin
        if (req_xfer) begin
          base_d = req_base;
          beat_d = '0;
          if (req_is_read) begin
            tag_d = bus_reqtag;
            lat_d = LAT_LOAD;
          end
        end
      end
      WR_DATA: if (req_xfer) beat_d = beat_q + BEAT_W'(1);
      RD_WAIT: begin
        lat_d  = lat_q - LAT_W'(1);
        beat_d = '0;
      end
      RD_RESP: if (resp_xfer) beat_d = beat_q + BEAT_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      base_q <= '0;
      beat_q <= '0;
      lat_q  <= '0;
      tag_q  <= '0;
    end else begin
      base_q <= base_d;
      beat_q <= beat_d;
      lat_q  <= lat_d;
      tag_q  <= tag_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sysbus_mem_responder.sv
// ============================================================================
// Module   : tb_sysbus_mem_responder
// Purpose  : Directed + randomized bench for sysbus_mem_responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sysbus_mem_responder;

  localparam int W       = 64;
  localparam int TW      = 13;
  localparam int BEATS   = 8;
  localparam int DEPTH   = 1024;
  localparam int LATENCY = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          bus_reqcyc = 1'b0;
  logic [W-1:0]  bus_req = '0;
  logic [TW-1:0] bus_reqtag = '0;
  logic          bus_respack = 1'b0;
  logic          bus_reqack;
  logic          bus_respcyc;
  logic [W-1:0]  bus_resp;
  logic [TW-1:0] bus_resptag;

  int checks = 0;
  int failures = 0;

  sysbus_mem_responder #(
    .BUS_DATA_WIDTH (W),
    .BUS_TAG_WIDTH  (TW),
    .BEATS          (BEATS),
    .DEPTH          (DEPTH),
    .LATENCY        (LATENCY)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus_reqcyc  (bus_reqcyc),
    .bus_req     (bus_req),
    .bus_reqtag  (bus_reqtag),
    .bus_reqack  (bus_reqack),
    .bus_respcyc (bus_respcyc),
    .bus_resp    (bus_resp),
    .bus_resptag (bus_resptag),
    .bus_respack (bus_respack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting for DUT at %0t", nm, $time);
  endtask

  // ---------------- transaction-level reference model ----------------
  int unsigned   cyc = 0;
  int            mode = 0;          // 0 idle, 1 write burst open, 2 read outstanding
  bit            armed = 1'b0;
  logic [W-1:0]  mmem [DEPTH];
  bit            known [DEPTH];
  int            wr_base = 0;
  int            wr_i = 0;
  int unsigned   resp_start = 0;
  logic [TW-1:0] exp_tag = '0;
  logic [W-1:0]  exp_data_q [$];
  bit            exp_known_q [$];

  function automatic bit m_reqack();
    return mode != 2;
  endfunction

  function automatic bit m_respcyc();
    return (mode == 2) && (cyc >= resp_start);
  endfunction

  function automatic int word_base(input logic [W-1:0] a);
    return int'(((a >> 3) / BEATS * BEATS) % DEPTH);
  endfunction

  always @(posedge clk) begin
    bit rx;
    bit sx;
    int b;
    rx = bus_reqcyc && m_reqack();
    sx = m_respcyc() && bus_respack;
    cyc++;
    if (!reset_n) begin
      mode  = 0;
      armed = 1'b1;
      exp_data_q.delete();
      exp_known_q.delete();
    end else if (mode == 0 && rx) begin
      b = word_base(bus_req);
      if (bus_reqtag[12]) begin
        for (int i = 0; i < BEATS; i++) begin
          exp_data_q.push_back(mmem[(b + i) % DEPTH]);
          exp_known_q.push_back(known[(b + i) % DEPTH]);
        end
        exp_tag    = bus_reqtag;
        resp_start = cyc + LATENCY;
        mode       = 2;
      end else begin
        wr_base = b;
        wr_i    = 0;
        mode    = 1;
      end
    end else if (mode == 1 && rx) begin
      mmem[(wr_base + wr_i) % DEPTH]  = bus_req;
      known[(wr_base + wr_i) % DEPTH] = 1'b1;
      wr_i++;
      if (wr_i == BEATS) mode = 0;
    end else if (mode == 2 && sx) begin
      void'(exp_data_q.pop_front());
      void'(exp_known_q.pop_front());
      if (exp_data_q.size() == 0) mode = 0;
    end
  end

  // Continuous comparison against the model, half a cycle from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      chk("model_reqack", bus_reqack, m_reqack());
      chk("model_respcyc", bus_respcyc, m_respcyc());
      if (m_respcyc() && exp_data_q.size() != 0) begin
        chk("model_resptag", bus_resptag, exp_tag);
        if (exp_known_q[0]) chk("model_resp", bus_resp, exp_data_q[0]);
      end
    end
  end

  // ---------------- drivers ----------------
  logic [W-1:0] got [BEATS];
  int           got_lat;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic [TW-1:0] t);
    int n;
    n = 0;
    bus_reqcyc = 1'b1;
    bus_req    = d;
    bus_reqtag = t;
    forever begin
      @(negedge clk);
      if (bus_reqack) break;
      n++;
      if (n > 200) begin
        timeout_fail("send");
        bus_reqcyc = 1'b0;
        return;
      end
    end
    tick();
    bus_reqcyc = 1'b0;
  endtask

  task automatic write_burst(input logic [W-1:0] addr, input logic [W-1:0] d0,
                             input bit rnd, input int gap_max);
    logic [W-1:0] d;
    send(addr, {1'b0, 4'b0001, 8'h00});
    for (int i = 0; i < BEATS; i++) begin
      repeat ($urandom_range(gap_max, 0)) tick();
      d = rnd ? {$urandom, $urandom} : d0 + W'(i);
      send(d, TW'($urandom));
    end
  endtask

  task automatic wait_respcyc(output int n);
    n = 0;
    while (!bus_respcyc && n < 100) begin
      tick();
      n++;
    end
    if (!bus_respcyc) timeout_fail("wait_respcyc");
  endtask

  task automatic collect(input logic [TW-1:0] tag, input int stall_beat,
                         input int stall_cyc, input logic [W-1:0] stall_exp);
    for (int b = 0; b < BEATS; b++) begin
      if (!bus_respcyc) begin
        timeout_fail("collect");
        return;
      end
      if (b == stall_beat) begin
        bus_respack = 1'b0;
        for (int k = 0; k < stall_cyc; k++) begin
          tick();
          chk("stall_respcyc", bus_respcyc, 1'b1);
          chk("stall_resp", bus_resp, stall_exp);
          chk("stall_resptag", bus_resptag, tag);
        end
      end
      bus_respack = 1'b1;
      got[b] = bus_resp;
      chk("beat_tag", bus_resptag, tag);
      tick();
    end
    bus_respack = 1'b0;
  endtask

  task automatic read_directed(input logic [W-1:0] addr, input logic [TW-1:0] tag,
                               input int stall_beat, input int stall_cyc,
                               input logic [W-1:0] stall_exp);
    send(addr, tag);
    wait_respcyc(got_lat);
    collect(tag, stall_beat, stall_cyc, stall_exp);
  endtask

  task automatic check_block_1000(input string nm);
    for (int i = 0; i < BEATS; i++) chk(nm, got[i], 64'h1000 + 64'(i));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int xfers;
    bit pend;
    bit do_rst;
    logic [W-1:0] addr;

    reset_n = 1'b0;
    repeat (2) tick();
    chk("reset_reqack", bus_reqack, 1'b1);
    chk("reset_respcyc", bus_respcyc, 1'b0);
    chk("reset_resp", bus_resp, 64'h0);
    chk("reset_resptag", bus_resptag, 13'h0);
    reset_n = 1'b1;
    tick();

    // Write burst then aligned read
    write_burst(64'h40, 64'h1000, 1'b0, 0);
    read_directed(64'h40, 13'h1301, -1, 0, 64'h0);
    chk("first_latency", 64'(got_lat), 64'd4);
    check_block_1000("aligned_read");
    chk("idle_after_read", bus_respcyc, 1'b0);

    // Misaligned address lands on the same block
    read_directed(64'h58, 13'h1302, -1, 0, 64'h0);
    check_block_1000("misaligned_read");

    // Backpressure on beat 3
    read_directed(64'h40, 13'h1303, 3, 5, 64'h1003);
    check_block_1000("stalled_read");

    // Second read presented while the first burst is streaming; it also wraps
    send(64'h40, 13'h1304);
    wait_respcyc(n);
    bus_reqcyc = 1'b1;
    bus_req    = 64'h2040;
    bus_reqtag = 13'h1305;
    for (int b = 0; b < BEATS; b++) begin
      bus_respack = 1'b1;
      chk("busy_reqack", bus_reqack, 1'b0);
      got[b] = bus_resp;
      tick();
    end
    bus_respack = 1'b0;
    check_block_1000("busy_first_read");
    chk("busy_reqack_after", bus_reqack, 1'b1);
    tick();
    bus_reqcyc = 1'b0;
    wait_respcyc(n);
    chk("second_read_latency", 64'(n), 64'd4);
    collect(13'h1305, -1, 0, 64'h0);
    check_block_1000("wrap_read");

    // Reset during beat 2 of a read
    send(64'h40, 13'h1306);
    wait_respcyc(n);
    bus_respack = 1'b1;
    tick();
    tick();
    bus_respack = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("midrst_respcyc", bus_respcyc, 1'b0);
    chk("midrst_reqack", bus_reqack, 1'b1);
    chk("midrst_resp", bus_resp, 64'h0);
    chk("midrst_resptag", bus_resptag, 13'h0);
    read_directed(64'h40, 13'h1307, -1, 0, 64'h0);
    check_block_1000("post_reset_read");

    // Randomized traffic checked by the model
    for (int t = 0; t < 150; t++) begin
      addr = 64'($urandom_range(255, 0)) + (64'($urandom_range(3, 0)) << 13);
      repeat ($urandom_range(2, 0)) tick();
      if ($urandom_range(1, 0) == 0) begin
        write_burst(addr, 64'h0, 1'b1, 2);
      end else begin
        send(addr, {1'b1, ($urandom_range(1, 0) != 0) ? 4'b0011 : 4'b0001,
                    8'($urandom)});
        do_rst = ($urandom_range(19, 0) == 0);
        xfers = 0;
        n = 0;
        while (xfers < BEATS && n < 500) begin
          bus_respack = 1'($urandom_range(1, 0));
          bus_reqcyc  = 1'($urandom_range(1, 0));
          bus_req     = {$urandom, $urandom};
          bus_reqtag  = TW'($urandom);
          if (do_rst && xfers == 2 && bus_respcyc) begin
            bus_reqcyc  = 1'b0;
            bus_respack = 1'b0;
            reset_n = 1'b0;
            tick();
            reset_n = 1'b1;
            break;
          end
          @(negedge clk);
          pend = bus_respcyc && bus_respack;
          tick();
          if (pend) xfers++;
          n++;
        end
        bus_reqcyc  = 1'b0;
        bus_respack = 1'b0;
        if (n >= 500) timeout_fail("random_read");
      end
    end

    bus_reqcyc  = 1'b0;
    bus_respack = 1'b0;
    repeat (4) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
